ans_decoder: RTL and testbench
==============================

Name: ans_decoder

Overview:
- rANS decoder paired with ans_encoder. Consumes the encoder's output word stream in reverse order (last-emitted word first) and reconstructs the symbols.
- Symbols come out in reverse of encode order.
- Frequency lookup is external: the block presents a slot index and a model returns the symbol, its count and its cumulative count in the same cycle.
- Sits between a LIFO word buffer (upstream) and the symbol sink (downstream).

Parameters:
- SYM_WIDTH, `SYM_WIDTH, width of one stream word and of a symbol id.
- CNT_WIDTH, `CNT_WIDTH, width of a per-symbol count.
- STATE_WIDTH, `STATE_WIDTH (= 4*SYM_WIDTH), coder state width; the encoder flushes exactly 4 words.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  run enable; low freezes all state, outputs held
- total_count  in  SYM_WIDTH+CNT_WIDTH  model total; static during a message
- in_data  in  SYM_WIDTH  stream word (reversed order)
- in_vld  in  1  in_data valid
- in_rdy  out  1  decoder accepts a word
- slot  out  SYM_WIDTH+CNT_WIDTH  lookup index = state % total_count (combinational from state)
- lk_sym  in  SYM_WIDTH  symbol owning slot
- lk_count  in  CNT_WIDTH  count of lk_sym (nonzero)
- lk_cumulative  in  SYM_WIDTH+CNT_WIDTH  cumulative count of lk_sym
- out  out  SYM_WIDTH  decoded symbol
- out_vld  out  1  out valid
- out_rdy  in  1  sink accepts out
- done  out  1  message fully decoded (sticky until reset)

Behaviour:
- Reset (async, rst_n low), all outputs: state=0, load counter=0, FSM=LOAD, in_rdy=1, out=0, out_vld=0, done=0.
- When ena is low:
  - No register changes.
  - A handshake with ena low does not count, on either side.
- FSM states:
  - LOAD:
    - in_rdy=1.
    - Each accepted word: state <= (state<<SYM_WIDTH)|in_data; load counter increments.
    - After the 4th word go to CHECK.
  - CHECK:
    - in_rdy=0.
    - If state == total_count+1 (the encoder initial value): done<=1 and go to DONE.
    - Otherwise go to DECODE.
  - DECODE (one cycle):
    - x = state.
    - state <= lk_count*(x/total_count) + (x%total_count) - lk_cumulative.
    - out <= lk_sym; out_vld <= 1; go to EMIT.
    - Div/mod are combinational, single cycle.
  - EMIT:
    - Hold out/out_vld until out_rdy.
    - On handshake: out_vld <= 0.
    - Next state is RENORM if state < total_count, else CHECK.
  - RENORM:
    - in_rdy=1.
    - Each accepted word: state <= (state<<SYM_WIDTH)|in_data.
    - Stay in RENORM while the new state < total_count; otherwise go to CHECK.
  - DONE:
    - in_rdy=0, out_vld=0.
    - Terminal until reset.
- in_rdy is high only in LOAD and RENORM. Words offered in any other state are not consumed.
- Arithmetic:
  - Intermediates use STATE_WIDTH+CNT_WIDTH bits, then truncate to STATE_WIDTH.
  - A valid stream never overflows.
- Empty message: 4 loaded words equal total_count+1 → done after CHECK, zero symbols out.
- Reset mid-message: everything aborts; the next word is treated as load word 1.
- Latency: LOAD → first out_vld = 2 cycles after the 4th word is accepted (CHECK, DECODE).

Test Plan (SYM_WIDTH=4, STATE_WIDTH=16, total_count=4; model: A=id1 cnt3 cum0, slots 0-2; B=id2 cnt1 cum3, slot 3):
- Encoder order A,A,B; feed 0,0,2,3 → load state 0x0023. Outputs B,A,A. Intermediate states 8, 6, 5; then done=1. in_rdy stays 0 after load.
- Renorm: encoder order B,B,B; feed 0,0,1,F,7. Decode gives states 7, then 1. Then RENORM accepts 7 → state 23, which decodes to 5 → done. Outputs B,B,B. Exactly 5 words consumed.
- Empty message: feed 0,0,0,5 → done=1 with no out_vld pulse.
- Backpressure: hold out_rdy=0 for 10 cycles in the A,A,B case. out stays B with out_vld=1, no word is consumed, and the state is unchanged.
- ena low for 5 cycles mid-LOAD with in_vld=1: no word is accepted. After resume, results match the A,A,B case.
- Assert rst_n low during EMIT → out_vld=0 and in_rdy=1 immediately (async). A fresh A,A,B stream then decodes correctly.

Source files
------------

// File: rtl/ans_decoder.sv
// ----------------------------------------------------------------------------
// ans_decoder
//   rANS decoder. It consumes the encoder's word stream in reverse (the
//   last-emitted word first) and reconstructs the symbols in reverse encode
//   order. The frequency model is external: the block drives `slot` and the
//   model answers with the owning symbol, its count and its cumulative count
//   in the same cycle.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   ena            run enable; low freezes every register
//   total_count    model total (static for a message)
//   in_data/in_vld/in_rdy   stream words from the upstream LIFO buffer
//   slot           lookup index = state % total_count (combinational)
//   lk_sym/lk_count/lk_cumulative   model response for `slot`
//   out/out_vld/out_rdy     decoded symbols to the sink
//   done           sticky end-of-message flag
// ----------------------------------------------------------------------------
module ans_decoder #(
   parameter int SYM_WIDTH   = 4,
   parameter int CNT_WIDTH   = 4,
   parameter int STATE_WIDTH = 4*SYM_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           ena,
   input  logic [SYM_WIDTH+CNT_WIDTH-1:0] total_count,
   input  logic [SYM_WIDTH-1:0]           in_data,
   input  logic                           in_vld,
   output logic                           in_rdy,
   output logic [SYM_WIDTH+CNT_WIDTH-1:0] slot,
   input  logic [SYM_WIDTH-1:0]           lk_sym,
   input  logic [CNT_WIDTH-1:0]           lk_count,
   input  logic [SYM_WIDTH+CNT_WIDTH-1:0] lk_cumulative,
   output logic [SYM_WIDTH-1:0]           out,
   output logic                           out_vld,
   input  logic                           out_rdy,
   output logic                           done
);

   localparam int TW = SYM_WIDTH + CNT_WIDTH;     // total / slot / cumulative
   localparam int XW = STATE_WIDTH + CNT_WIDTH;   // arithmetic intermediates

   localparam logic [2:0] LOAD   = 3'd0;
   localparam logic [2:0] CHECK  = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] EMIT   = 3'd3;
   localparam logic [2:0] RENORM = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

   // model response bundled for readability
   typedef struct packed {
      logic [SYM_WIDTH-1:0] sym;
      logic [CNT_WIDTH-1:0] count;
      logic [TW-1:0]        cum;
   } lk_rsp_t;

   logic [2:0]             fsm;
   logic [1:0]             ld_cnt;
   logic [STATE_WIDTH-1:0] state;

   lk_rsp_t                lk;
   logic [XW-1:0]          x_ext;
   logic [XW-1:0]          tot_ext;
   logic [XW-1:0]          quot;
   logic [XW-1:0]          rem;
   logic [STATE_WIDTH-1:0] state_dec;
   logic [STATE_WIDTH-1:0] state_shift;
   logic                   state_lt;
   logic                   shift_lt;
   logic                   is_init;
   logic                   take_in;

   assign lk = '{sym: lk_sym, count: lk_count, cum: lk_cumulative};

   // single-cycle divide / modulo on the current state
   assign x_ext   = XW'(state);
   assign tot_ext = XW'(total_count);
   assign quot    = x_ext / tot_ext;
   assign rem     = x_ext % tot_ext;
   assign slot    = TW'(rem);

   // decode step: x' = count*(x/T) + (x%T) - cum, truncated to the state width
   assign state_dec   = STATE_WIDTH'(XW'(lk.count) * quot + rem - XW'(lk.cum));
   // shift a new word in below the current state (load and renormalise)
   assign state_shift = {state[STATE_WIDTH-SYM_WIDTH-1:0], in_data};

   assign state_lt = x_ext < tot_ext;
   assign shift_lt = XW'(state_shift) < tot_ext;
   // the encoder starts from total+1, so seeing it again means the stream is exhausted
   assign is_init  = x_ext == (tot_ext + XW'(1));

   assign in_rdy  = (fsm == LOAD) || (fsm == RENORM);
   assign take_in = ena && in_vld && in_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm     <= LOAD;
         ld_cnt  <= 2'd0;
         state   <= '0;
         out     <= '0;
         out_vld <= 1'b0;
         done    <= 1'b0;
      end else if (ena) begin
         case (fsm)
            LOAD: begin
               if (take_in) begin
                  state  <= state_shift;
                  ld_cnt <= ld_cnt + 2'd1;
                  if (ld_cnt == 2'd3) fsm <= CHECK;
               end
            end
            CHECK: begin
               if (is_init) begin
                  done <= 1'b1;
                  fsm  <= DONE;
               end else begin
                  fsm  <= DECODE;
               end
            end
            DECODE: begin
               state   <= state_dec;
               out     <= lk.sym;
               out_vld <= 1'b1;
               fsm     <= EMIT;
            end
            EMIT: begin
               // state already holds the post-decode value here
               if (out_rdy) begin
                  out_vld <= 1'b0;
                  fsm     <= state_lt ? RENORM : CHECK;
               end
            end
            RENORM: begin
               if (take_in) begin
                  state <= state_shift;
                  if (!shift_lt) fsm <= CHECK;
               end
            end
            DONE: begin
            end
            default: fsm <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_ans_decoder.sv
module tb_ans_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] total_count;
   logic [3:0] in_data;
   logic       in_vld;
   logic       in_rdy;
   logic [7:0] slot;
   logic [3:0] lk_sym;
   logic [3:0] lk_count;
   logic [7:0] lk_cumulative;
   logic [3:0] out;
   logic       out_vld;
   logic       out_rdy;
   logic       done;

   int n_vec = 0;
   int n_err = 0;

   // frequency model: cnt==0 means the id is absent
   int cnt [16];
   int cum [16];
   int T;

   int         msg[$];
   logic [3:0] words[$];
   int         exp_syms[$];
   int         exp_slot[$];

   ans_decoder #(.SYM_WIDTH(4), .CNT_WIDTH(4), .STATE_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .total_count(total_count),
      .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy), .slot(slot),
      .lk_sym(lk_sym), .lk_count(lk_count), .lk_cumulative(lk_cumulative),
      .out(out), .out_vld(out_vld), .out_rdy(out_rdy), .done(done)
   );

   always #5 clk = ~clk;

   // external model lookup: symbol whose [cum, cum+cnt) range holds slot
   always_comb begin
      lk_sym        = 4'd0;
      lk_count      = 4'd1;
      lk_cumulative = 8'd0;
      for (int i = 0; i < 16; i++) begin
         if (cnt[i] != 0 && int'(slot) >= cum[i] && int'(slot) < cum[i] + cnt[i]) begin
            lk_sym        = 4'(i);
            lk_count      = 4'(cnt[i]);
            lk_cumulative = 8'(cum[i]);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic finalize_model();
      int acc = 0;
      for (int i = 0; i < 16; i++) begin
         cum[i] = acc;
         acc += cnt[i];
      end
      T = acc;
      total_count = 8'(T);
   endtask

   // Reference rANS encoder (radix 16, state range [T,16T)). Produces the word
   // stream in decoder read order, the expected symbols in decode order and the
   // expected post-decode slot for each symbol. Rejects messages whose encoder
   // state hits T+1 mid-stream, since that would read as end-of-message.
   function automatic bit encode_msg();
      longint x = T + 1;
      logic [3:0] em[$];
      words.delete(); exp_syms.delete(); exp_slot.delete();
      foreach (msg[i]) begin
         int s = msg[i];
         while (x >= 16 * cnt[s]) begin
            em.push_back(4'(x & 15));
            x = x >> 4;
         end
         exp_slot.push_front(int'(x % T));
         x = (x / cnt[s]) * T + (x % cnt[s]) + cum[s];
         if (x == T + 1) return 1'b0;
         exp_syms.push_front(s);
      end
      for (int k = 0; k < 4; k++) em.push_back(4'((x >> (4*k)) & 15));
      for (int k = em.size() - 1; k >= 0; k--) words.push_back(em[k]);
      return 1'b1;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; ena = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; in_data = 4'd0;
      repeat (2) @(negedge clk);
      check("rst_in_rdy", in_rdy, 1);
      check("rst_out_vld", out_vld, 0);
      check("rst_done", done, 0);
      check("rst_out", out, 0);
      check("rst_slot", slot, 0);
      rst_n = 1'b1;
   endtask

   // Drives one message. stall: cycles out_rdy is held low at the first
   // output; ena_gap: words loaded before a 5-cycle ena-low window (-1: none);
   // abort: async reset as soon as the first output appears.
   task automatic run_msg(input int stall, input int ena_gap, input bit abort);
      int consumed = 0;
      int emitted  = 0;
      int hold     = stall;
      int gap      = 0;
      bit gapped   = 1'b0;
      bit aborted  = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (done) break;
         if (ena_gap >= 0 && !gapped && consumed == ena_gap) begin
            gapped = 1'b1;
            gap    = 5;
         end
         ena = (gap == 0);
         if (gap > 0) gap--;
         in_vld  = (consumed < words.size()) && (!ena || $urandom_range(0, 3) != 0);
         in_data = (consumed < words.size()) ? words[consumed] : 4'($urandom);
         if (out_vld && abort) begin
            #2 rst_n = 1'b0;
            #1;
            check("abort_out_vld", out_vld, 0);
            check("abort_in_rdy", in_rdy, 1);
            check("abort_done", done, 0);
            @(negedge clk);
            rst_n   = 1'b1;
            aborted = 1'b1;
            break;
         end
         if (out_vld && hold > 0) begin
            out_rdy = 1'b0;
            hold--;
            if (emitted < exp_syms.size()) begin
               check("hold_out", out, exp_syms[emitted]);
               check("hold_slot", slot, exp_slot[emitted]);
            end
            check("hold_in_rdy", in_rdy, 0);
         end else begin
            out_rdy = ($urandom_range(0, 3) != 0);
         end
         if (ena && in_vld && in_rdy) consumed++;
         if (ena && out_vld && out_rdy) begin
            if (emitted < exp_syms.size()) begin
               check("out_sym", out, exp_syms[emitted]);
               check("out_slot", slot, exp_slot[emitted]);
            end else begin
               check("out_count", emitted + 1, exp_syms.size());
            end
            emitted++;
         end
      end
      in_vld = 1'b0; out_rdy = 1'b0; ena = 1'b1;
      if (!aborted) begin
         check("done", done, 1);
         check("words_used", consumed, words.size());
         check("syms_out", emitted, exp_syms.size());
         check("done_out_vld", out_vld, 0);
         // words offered after completion must be refused
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_vld  = 1'b1;
            in_data = 4'($urandom);
            check("done_in_rdy", in_rdy, 0);
         end
         in_vld = 1'b0;
      end
   endtask

   task automatic directed_model();
      for (int i = 0; i < 16; i++) cnt[i] = 0;
      cnt[1] = 3;   // A: slots 0-2
      cnt[2] = 1;   // B: slot 3
      finalize_model();
   endtask

   initial begin
      bit ok;
      rst_n = 1'b0; ena = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; in_data = 4'd0;
      directed_model();

      // A,A,B : stream 0,0,2,3 -> B,A,A
      do_reset();
      msg = '{1, 1, 2};
      ok = encode_msg();
      run_msg(0, -1, 1'b0);

      // B,B,B : one renormalisation word, 5 words total
      do_reset();
      msg = '{2, 2, 2};
      ok = encode_msg();
      run_msg(0, -1, 1'b0);

      // empty message: 0,0,0,5
      do_reset();
      msg.delete();
      ok = encode_msg();
      run_msg(0, -1, 1'b0);

      // output backpressure for 10 cycles
      do_reset();
      msg = '{1, 1, 2};
      ok = encode_msg();
      run_msg(10, -1, 1'b0);

      // ena low for 5 cycles mid-load with words on offer
      do_reset();
      run_msg(0, 2, 1'b0);

      // async reset during EMIT, then a fresh stream with no extra reset
      do_reset();
      run_msg(0, -1, 1'b1);
      run_msg(0, -1, 1'b0);

      // random models and messages
      for (int r = 0; r < 10; r++) begin
         int nsym = $urandom_range(2, 16);
         for (int i = 0; i < 16; i++) cnt[i] = (i < nsym) ? $urandom_range(1, 15) : 0;
         finalize_model();
         ok = 1'b0;
         for (int t = 0; t < 20 && !ok; t++) begin
            int len = $urandom_range(1, 12);
            msg.delete();
            for (int k = 0; k < len; k++) msg.push_back($urandom_range(0, nsym - 1));
            ok = encode_msg();
         end
         if (!ok) begin
            msg.delete();
            ok = encode_msg();
         end
         do_reset();
         run_msg($urandom_range(0, 4), (r % 3 == 0) ? $urandom_range(0, 3) : -1, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
